// File: rtl/snake_body_engine.sv
// Snake body engine: holds the segment list, advances it one tile per move tick,
// and resolves wall hits, self hits and food growth in a follow-up CHECK cycle.
module snake_body_engine #(
   parameter int GRID_W  = 10,
   parameter int GRID_H  = 10,
   parameter int MAX_LEN = 100,
   parameter int START_X = 5,
   parameter int START_Y = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   move_tick,
   input  logic [1:0]             dir_in,
   input  logic                   dir_valid,
   input  logic [31:0]            food_x,
   input  logic [31:0]            food_y,
   output logic [32*MAX_LEN-1:0]  x_values,
   output logic [32*MAX_LEN-1:0]  y_values,
   output logic [7:0]             length,
   output logic                   food_eaten,
   output logic                   update_done,
   output logic                   game_done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state;
   logic [1:0]  dir;
   logic [1:0]  pend_dir;
   logic [1:0]  eff_dir;
   logic [31:0] x_seg [MAX_LEN];
   logic [31:0] y_seg [MAX_LEN];
   logic [31:0] nx;
   logic [31:0] ny;
   logic [31:0] mx;
   logic [31:0] my;
   logic        wall_hit;
   logic        self_hit;
   logic        hit_food;
   logic        grow;
   int          len_i;

   assign len_i = int'(length);

   // A request for the exact reverse of travel is dropped at commit time
   assign eff_dir = (pend_dir == (dir ^ 2'b10)) ? dir : pend_dir;

   always_comb begin
      mx = x_seg[0];
      my = y_seg[0];
      case (eff_dir)
         2'd0:    mx = x_seg[0] + 32'd1;
         2'd1:    my = y_seg[0] + 32'd1;
         2'd2:    mx = x_seg[0] - 32'd1;
         default: my = y_seg[0] - 32'd1;
      endcase
   end

   assign wall_hit = (nx >= 32'(GRID_W)) || (ny >= 32'(GRID_H));
   assign hit_food = (nx == food_x) && (ny == food_y);
   assign grow     = hit_food && (len_i < MAX_LEN);

   // The tail slot moves away this step unless the snake grows
   always_comb begin
      self_hit = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (k < len_i && (k != len_i - 1 || grow) &&
             x_seg[k] == nx && y_seg[k] == ny)
            self_hit = 1'b1;
      end
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
      assign x_values[32*g +: 32] = x_seg[g];
      assign y_values[32*g +: 32] = y_seg[g];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         dir         <= 2'd0;
         pend_dir    <= 2'd0;
         nx          <= 32'd0;
         ny          <= 32'd0;
         length      <= 8'd0;
         food_eaten  <= 1'b0;
         update_done <= 1'b0;
         game_done   <= 1'b0;
         for (int k = 0; k < MAX_LEN; k++) begin
            x_seg[k] <= '1;
            y_seg[k] <= '1;
         end
      end else begin
         food_eaten  <= 1'b0;
         update_done <= 1'b0;
         if (dir_valid)
            pend_dir <= dir_in;
         else if (start)
            pend_dir <= 2'd0;
         if (start) begin
            state     <= S_RUN;
            dir       <= 2'd0;
            length    <= 8'd3;
            game_done <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
               if (k < 3) begin
                  x_seg[k] <= 32'(START_X) - 32'(k);
                  y_seg[k] <= 32'(START_Y);
               end else begin
                  x_seg[k] <= '1;
                  y_seg[k] <= '1;
               end
            end
         end else begin
            case (state)
               S_RUN: begin
                  if (move_tick) begin
                     dir   <= eff_dir;
                     nx    <= mx;
                     ny    <= my;
                     state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (wall_hit || self_hit) begin
                     state     <= S_DONE;
                     game_done <= 1'b1;
                  end else begin
                     for (int k = 1; k < MAX_LEN; k++) begin
                        if (k < len_i || (grow && k == len_i)) begin
                           x_seg[k] <= x_seg[k-1];
                           y_seg[k] <= y_seg[k-1];
                        end
                     end
                     x_seg[0]    <= nx;
                     y_seg[0]    <= ny;
                     if (grow)
                        length <= length + 8'd1;
                     update_done <= 1'b1;
                     food_eaten  <= hit_food;
                     state       <= S_RUN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: a behavioural snake model predicts
// each tick's outcome, and a negedge monitor matches DUT responses against it.
module tb_snake_body_engine;

   localparam int ML = 100;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            move_tick;
   logic [1:0]      dir_in;
   logic            dir_valid;
   logic [31:0]     food_x;
   logic [31:0]     food_y;
   logic [32*ML-1:0] x_values;
   logic [32*ML-1:0] y_values;
   logic [7:0]      length;
   logic            food_eaten;
   logic            update_done;
   logic            game_done;

   always #5 clk = ~clk;

   snake_body_engine dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .move_tick   (move_tick),
      .dir_in      (dir_in),
      .dir_valid   (dir_valid),
      .food_x      (food_x),
      .food_y      (food_y),
      .x_values    (x_values),
      .y_values    (y_values),
      .length      (length),
      .food_eaten  (food_eaten),
      .update_done (update_done),
      .game_done   (game_done)
   );

   typedef struct {
      bit          coll;
      int          stamp;
      logic [31:0] hx;
      logic [31:0] hy;
      logic [31:0] tx;
      logic [31:0] ty;
      int          len;
      bit          food;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_m;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          gd_q = 1'b0;
   logic [31:0] mx [ML];
   logic [31:0] my [ML];
   int          mlen;
   int          mdir;
   int          mpend;
   bit          mdone = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] xs(input int k);
      return x_values[32*k +: 32];
   endfunction

   function automatic logic [31:0] ys(input int k);
      return y_values[32*k +: 32];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (update_done || (game_done && !gd_q)) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", {30'd0, update_done, game_done}, 32'd0);
         end else begin
            e_m = sb.pop_front();
            chk("latency", 32'(cyc - e_m.stamp), 32'd2);
            chk("game_done", {31'd0, game_done}, {31'd0, e_m.coll});
            chk("update_done", {31'd0, update_done}, {31'd0, !e_m.coll});
            chk("food_eaten", {31'd0, food_eaten}, {31'd0, e_m.food});
            chk("length", {24'd0, length}, 32'(e_m.len));
            chk("head_x", xs(0), e_m.hx);
            chk("head_y", ys(0), e_m.hy);
            chk("tail_x", xs(e_m.len - 1), e_m.tx);
            chk("tail_y", ys(e_m.len - 1), e_m.ty);
            if (e_m.len < ML)
               chk("past_tail", xs(e_m.len), 32'hFFFF_FFFF);
         end
      end
      gd_q = game_done;
   end

   task automatic m_start();
      for (int k = 0; k < ML; k++) begin
         mx[k] = '1;
         my[k] = '1;
      end
      mx[0] = 32'd5; mx[1] = 32'd4; mx[2] = 32'd3;
      my[0] = 32'd5; my[1] = 32'd5; my[2] = 32'd5;
      mlen  = 3;
      mdir  = 0;
      mpend = 0;
      mdone = 1'b0;
   endtask

   task automatic m_step();
      exp_t        e;
      logic [31:0] nx;
      logic [31:0] ny;
      bit          eat;
      bit          grow;
      bit          hit;
      int          eff;
      eff  = (mpend == ((mdir + 2) % 4)) ? mdir : mpend;
      mdir = eff;
      nx   = mx[0];
      ny   = my[0];
      case (eff)
         0: nx = nx + 32'd1;
         1: ny = ny + 32'd1;
         2: nx = nx - 32'd1;
         default: ny = ny - 32'd1;
      endcase
      eat  = (nx == food_x) && (ny == food_y);
      grow = eat && (mlen < ML);
      hit  = (nx >= 32'd10) || (ny >= 32'd10);
      for (int k = 0; k < (grow ? mlen : mlen - 1); k++)
         if (mx[k] == nx && my[k] == ny) hit = 1'b1;
      e.stamp = cyc;
      e.coll  = hit;
      if (hit) begin
         mdone  = 1'b1;
         e.food = 1'b0;
      end else begin
         if (grow) mlen++;
         for (int k = mlen - 1; k > 0; k--) begin
            mx[k] = mx[k-1];
            my[k] = my[k-1];
         end
         mx[0]  = nx;
         my[0]  = ny;
         e.food = eat;
      end
      e.hx  = mx[0];
      e.hy  = my[0];
      e.tx  = mx[mlen-1];
      e.ty  = my[mlen-1];
      e.len = mlen;
      sb.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_start();
      @(negedge clk);
   endtask

   task automatic set_dir(input int d);
      dir_in    = 2'(d);
      dir_valid = 1'b1;
      @(negedge clk);
      dir_valid = 1'b0;
      mpend     = d;
   endtask

   task automatic set_food(input int fx, input int fy);
      food_x = 32'(fx);
      food_y = 32'(fy);
   endtask

   task automatic tick();
      if (!mdone) m_step();
      move_tick = 1'b1;
      @(negedge clk);
      move_tick = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      move_tick = 1'b0;
      dir_in    = 2'd0;
      dir_valid = 1'b0;
      set_food(0, 0);
      repeat (2) @(negedge clk);
      chk("rst_length", {24'd0, length}, 32'd0);
      chk("rst_slot0_x", xs(0), 32'hFFFF_FFFF);
      chk("rst_game_done", {31'd0, game_done}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_length", {24'd0, length}, 32'd0);

      do_start();
      chk("init_s0_x", xs(0), 32'd5);
      chk("init_s0_y", ys(0), 32'd5);
      chk("init_s1_x", xs(1), 32'd4);
      chk("init_s2_x", xs(2), 32'd3);
      chk("init_s2_y", ys(2), 32'd5);
      chk("init_s3_x", xs(3), 32'hFFFF_FFFF);
      chk("init_length", {24'd0, length}, 32'd3);
      chk("init_game_done", {31'd0, game_done}, 32'd0);

      repeat (3) tick();
      chk("three_ticks_head", xs(0), 32'd8);
      chk("three_ticks_tail", xs(2), 32'd6);

      do_start();
      set_dir(2);
      tick();
      chk("reverse_head", xs(0), 32'd6);

      do_start();
      set_food(6, 5);
      tick();
      chk("grow_slot3_x", xs(3), 32'd3);
      set_food(0, 0);

      do_start();
      repeat (5) tick();
      chk("wall_done", {31'd0, game_done}, 32'd1);
      repeat (2) tick();
      chk("done_hold", {31'd0, game_done}, 32'd1);
      chk("done_head", xs(0), 32'd9);
      do_start();
      chk("restart_head", xs(0), 32'd5);
      chk("restart_done", {31'd0, game_done}, 32'd0);

      set_dir(3);
      repeat (6) tick();
      chk("wall_up_done", {31'd0, game_done}, 32'd1);
      chk("wall_up_head_y", ys(0), 32'd0);

      do_start();
      set_food(6, 5);
      tick();
      set_food(7, 5);
      tick();
      set_food(0, 0);
      set_dir(1);
      tick();
      set_dir(2);
      tick();
      set_dir(3);
      tick();
      chk("self_hit_done", {31'd0, game_done}, 32'd1);
      chk("self_hit_len", {24'd0, length}, 32'd5);

      do_start();
      move_tick = 1'b1;
      @(negedge clk);
      move_tick = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mdone = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_length", {24'd0, length}, 32'd0);
      chk("abort_s0_x", xs(0), 32'hFFFF_FFFF);
      chk("abort_s2_y", ys(2), 32'hFFFF_FFFF);
      chk("abort_done", {31'd0, game_done}, 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_body_engine.md
SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 10, meaning board width in tiles.
REQ-002 SHALL have parameter GRID_H, default 10, meaning board height in tiles.
REQ-003 SHALL have parameter MAX_LEN, default 100, meaning segment slots in the packed outputs.
REQ-004 SHALL have parameters START_X/START_Y, default 5/5, meaning the initial head tile.
REQ-005 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse; (re)initialises the snake.
REQ-008 SHALL have port move_tick  input  1  one-cycle pulse; advances the snake one tile.
REQ-009 SHALL have port dir_in  input  2  requested direction: 0=right, 1=down, 2=left, 3=up.
REQ-010 SHALL have port dir_valid  input  1  qualifies dir_in for one cycle.
REQ-011 SHALL have port food_x / food_y  input  32 each  current food tile.
REQ-012 SHALL have port x_values / y_values  output  32*MAX_LEN each  slot k in bits [32k+31:32k]; slot 0 is the head; unused slots are 32'hFFFFFFFF.
REQ-013 SHALL have port length  output  8  number of valid segments.
REQ-014 SHALL have port food_eaten  output  1  one-cycle pulse when the head enters the food tile.
REQ-015 SHALL have port update_done  output  1  one-cycle pulse when new positions are visible.
REQ-016 SHALL have port game_done  output  1  high while the game is over.

Function
REQ-017 SHALL implement states IDLE, RUN, CHECK and DONE.
REQ-018 SHALL leave IDLE or DONE for RUN on start, loading a length-3 snake: (START_X,START_Y), (START_X-1,START_Y), (START_X-2,START_Y); all other slots -1; direction right; game_done low.
REQ-019 SHALL honour start in RUN or CHECK as well, with the same initialisation (restart).
REQ-020 SHALL latch dir_in into pending direction on dir_valid in any state; the latest request before a tick wins.
REQ-021 SHALL discard a pending direction that is the exact reverse of the current direction.
REQ-022 SHALL, in RUN on move_tick at cycle T, commit the pending direction, register the new head (head +/-1 on one axis, 32-bit wrapping arithmetic) and go to CHECK at T+1.
REQ-023 SHALL ignore move_tick while in IDLE, CHECK or DONE.
REQ-024 SHALL flag a wall hit in CHECK when new head x >= GRID_W or y >= GRID_H, compared unsigned so that -1 is out of range.
REQ-025 SHALL set grow when the new head equals (food_x, food_y) and length < MAX_LEN.
REQ-026 SHALL flag a self hit when the new head equals any valid segment, excluding the tail slot (length-1) unless grow is set.
REQ-027 SHALL, on a wall or self hit, go to DONE at T+2 with game_done high and positions unchanged.
REQ-028 SHALL otherwise shift slot k to slot k+1, write the new head to slot 0 and return to RUN.
REQ-029 SHALL, on grow, keep the old tail and increment length; otherwise it SHALL write -1 into the vacated slot.
REQ-030 SHALL make updated outputs valid in cycle T+2 and pulse update_done in T+2; a 2-cycle latency tick-to-update.
REQ-031 SHALL pulse food_eaten in T+2 whenever the head enters the food tile, even when length is saturated at MAX_LEN (no growth).
REQ-032 SHALL give wall/self hit priority over food_eaten: neither food_eaten nor update_done pulses on a collision.
REQ-033 SHALL hold game_done high in DONE until start or reset.
REQ-034 SHALL never let length exceed MAX_LEN or fall below 3 outside IDLE.

Reset
REQ-035 SHALL, on reset assertion, asynchronously go to IDLE with all slots 32'hFFFFFFFF, length 0, direction right, pending direction right, and food_eaten, update_done and game_done low.
REQ-036 SHALL abandon any in-flight CHECK on reset, with no partial shift visible.
REQ-037 SHALL stay in IDLE after reset release until start.

Verification
REQ-038 SHALL be covered by: reset then start -> slots 0..2 = (5,5),(4,5),(3,5), slot 3 = -1, length 3, game_done 0.
REQ-039 SHALL be covered by: start, three move_ticks right with food at (0,0) -> head (8,5), tail (6,5), length 3, three update_done pulses, each 2 cycles after its tick.
REQ-040 SHALL be covered by: start, dir_in=2 (left) with dir_valid, then a tick -> reversal ignored, head (6,5).
REQ-041 SHALL be covered by: start, food (6,5), a tick -> food_eaten pulse, length 4, slot 3 = (3,5).
REQ-042 SHALL be covered by: start, five ticks right -> the fifth tick gives new head x=10 (wall), game_done 1 at T+2, slots unchanged, no update_done; later ticks ignored; start restarts the snake.
REQ-043 SHALL be covered by: reset asserted the cycle after a tick -> IDLE state, all slots -1, length 0, no update_done.
